ysyx_23060072_mem_arbiter: RTL and testbench

Shares the core's single memory bus port between the instruction fetch requester (IF stage) and the load/store requester (LSU stage). It supports one outstanding transaction, uses LSU-priority arbitration with an anti-starvation counter for IF, and routes the response back to whichever requester owns the transaction. It sits between the if/lsu stages and the external memory/bus interface.

---
 rtl/ysyx_23060072_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_ysyx_23060072_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060072_mem_arbiter.sv
// Two-requester (IF/LSU) memory port arbiter, one outstanding transaction.
// Ports: if_* fetch side, lsu_* load/store side, mem_* bus side, busy_o/err_o status.
// Optional: define MEM_ARB_TIMEOUT_EN to enable the response watchdog.
module ysyx_23060072_mem_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_LSU_BURST = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_wstrb_i,
  output logic                lsu_gnt_o,
  output logic                lsu_rvalid_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o,
  output logic                err_o
);

  localparam int SW = $clog2(MAX_LSU_BURST + 1);
  localparam int BW = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BW-1:0]     wstrb_q;
  logic [SW-1:0]     starve_q;

  logic              starved;
  logic              lsu_win;
  logic              to_hit;
  logic              gnt_ev;
  logic              rsp_ev;
  logic [DATA_W-1:0] rsp_data;

  // owner_q: 1 = LSU, 0 = IF
  assign starved = (starve_q == SW'(MAX_LSU_BURST));
  assign lsu_win = lsu_req_i && !(if_req_i && starved);

  assign gnt_ev = (state_q == REQ) && (mem_gnt_i || to_hit);
  assign rsp_ev = (state_q == RESP) && (mem_rvalid_i || to_hit);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q;

  assign to_hit = (state_q != IDLE) && (tcnt_q == TW'(TIMEOUT));
  assign err_o  = (gnt_ev && !mem_gnt_i) || (rsp_ev && !mem_rvalid_i);
  assign rsp_data = mem_rvalid_i ? mem_rdata_i : DATA_W'(32'hDEADBEEF);

  // counts cycles spent in the current state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
    end else if (state_q == IDLE || gnt_ev || rsp_ev) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_q + 1'b1;
    end
  end
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT != 0);
  assign to_hit   = 1'b0;
  assign err_o    = 1'b0;
  assign rsp_data = mem_rdata_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      starve_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (lsu_win) begin
            state_q  <= REQ;
            owner_q  <= 1'b1;
            we_q     <= lsu_we_i;
            addr_q   <= lsu_addr_i;
            wdata_q  <= lsu_wdata_i;
            wstrb_q  <= lsu_wstrb_i;
            if (!if_req_i) begin
              starve_q <= '0;
            end else if (!starved) begin
              starve_q <= starve_q + 1'b1;
            end
          end else if (if_req_i) begin
            state_q  <= REQ;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= if_addr_i;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            starve_q <= '0;
          end else begin
            starve_q <= '0;
          end
        end
        REQ: begin
          if (gnt_ev) state_q <= RESP;
        end
        RESP: begin
          if (rsp_ev) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = mem_req_o & we_q;
  assign mem_addr_o  = mem_req_o ? addr_q : '0;
  assign mem_wdata_o = mem_req_o ? wdata_q : '0;
  assign mem_wstrb_o = mem_req_o ? wstrb_q : '0;

  assign if_gnt_o     = gnt_ev && !owner_q;
  assign lsu_gnt_o    = gnt_ev && owner_q;
  assign if_rvalid_o  = rsp_ev && !owner_q;
  assign lsu_rvalid_o = rsp_ev && owner_q;
  assign if_rdata_o   = if_rvalid_o ? rsp_data : '0;
  assign lsu_rdata_o  = lsu_rvalid_o ? rsp_data : '0;

endmodule

// File: tb/tb_ysyx_23060072_mem_arbiter.sv
// Bench for ysyx_23060072_mem_arbiter: directed scenarios plus
// randomized traffic checked against a transaction-level model.
module tb_ysyx_23060072_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          lsu_req_i = 1'b0;
  logic          lsu_we_i = 1'b0;
  logic [AW-1:0] lsu_addr_i = '0;
  logic [DW-1:0] lsu_wdata_i = '0;
  logic [3:0]    lsu_wstrb_i = '0;
  logic          lsu_gnt_o;
  logic          lsu_rvalid_o;
  logic [DW-1:0] lsu_rdata_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [3:0]    mem_wstrb_o;
  logic          mem_gnt_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          busy_o;
  logic          err_o;

  always #5 clk = ~clk;

  ysyx_23060072_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .MAX_LSU_BURST(MAXB), .TIMEOUT(255)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o),
    .if_rdata_o(if_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_wstrb_i(lsu_wstrb_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Transaction-level model: m_ph 0 = no transaction,
  // 1 = waiting for bus accept, 2 = waiting for response.
  int          m_ph = 0;
  logic        m_lsu = 1'b0;
  logic        m_we = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_wstrb = '0;
  int          m_st = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_lsu <= 1'b0; m_we <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_wstrb <= '0;
      m_st <= 0;
    end else if (m_ph == 0) begin
      if (if_req_i && (!lsu_req_i || m_st == MAXB)) begin
        m_ph <= 1; m_lsu <= 1'b0; m_we <= 1'b0;
        m_addr <= if_addr_i; m_wdata <= '0;
        m_wstrb <= '0; m_st <= 0;
      end else if (lsu_req_i) begin
        m_ph <= 1; m_lsu <= 1'b1; m_we <= lsu_we_i;
        m_addr <= lsu_addr_i; m_wdata <= lsu_wdata_i;
        m_wstrb <= lsu_wstrb_i;
        m_st <= if_req_i ? ((m_st < MAXB) ? m_st + 1 : MAXB) : 0;
      end else begin
        m_st <= 0;
      end
    end else if (m_ph == 1) begin
      if (mem_gnt_i) m_ph <= 2;
    end else begin
      if (mem_rvalid_i) m_ph <= 0;
    end
  end

  always @(negedge clk) begin
    logic e_req, e_ig, e_lg, e_iv, e_lv;
    e_req = (m_ph == 1);
    e_ig = e_req && mem_gnt_i && !m_lsu;
    e_lg = e_req && mem_gnt_i && m_lsu;
    e_iv = (m_ph == 2) && mem_rvalid_i && !m_lsu;
    e_lv = (m_ph == 2) && mem_rvalid_i && m_lsu;
    chk("mem_req", mem_req_o, e_req);
    chk("mem_we", mem_we_o, e_req ? m_we : 1'b0);
    chk("mem_addr", mem_addr_o, e_req ? m_addr : 32'h0);
    chk("mem_wdata", mem_wdata_o, e_req ? m_wdata : 32'h0);
    chk("mem_wstrb", mem_wstrb_o, e_req ? m_wstrb : 4'h0);
    chk("if_gnt", if_gnt_o, e_ig);
    chk("lsu_gnt", lsu_gnt_o, e_lg);
    chk("if_rvalid", if_rvalid_o, e_iv);
    chk("lsu_rvalid", lsu_rvalid_o, e_lv);
    chk("if_rdata", if_rdata_o, e_iv ? mem_rdata_i : 32'h0);
    chk("lsu_rdata", lsu_rdata_o, e_lv ? mem_rdata_i : 32'h0);
    chk("busy", busy_o, m_ph != 0);
    chk("err", err_o, 1'b0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  // IF waits while LSU issues 6 loads: L L L L I L L
  task automatic run_burst(input string tag);
    bit exp_o [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int n = 0;
    int nl = 0;
    int cyc = 0;
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h8000_0008;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0;
    lsu_addr_i = 32'h300;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    while (n < 7 && cyc < 60) begin
      look();
      if (lsu_gnt_o || if_gnt_o) begin
        chk($sformatf("%s_order%0d", tag, n), lsu_gnt_o, exp_o[n]);
        if (lsu_gnt_o) nl++;
        n++;
      end
      tick();
      cyc++;
      if (nl >= 6) lsu_req_i = 1'b0;
    end
    if (n < 7) chk({tag, "_grants"}, n, 7);
    if_req_i = 1'b0; lsu_req_i = 1'b0; mem_gnt_i = 1'b0;
    tick();
    tick();
    mem_rvalid_i = 1'b0;
    look();
    chk({tag, "_idle"}, busy_o, 1'b0);
  endtask

  initial begin
    logic if_seen;
    logic lsu_seen;
    repeat (2) tick();
    look();
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_mem_req", mem_req_o, 1'b0);
    tick();
    rst_n = 1'b1;

    // single IF read
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h8000_0000; mem_gnt_i = 1'b1;
    look();
    chk("t1_c0_req", mem_req_o, 1'b0);
    tick();
    look();
    chk("t1_c1_req", mem_req_o, 1'b1);
    chk("t1_c1_addr", mem_addr_o, 32'h8000_0000);
    chk("t1_c1_gnt", if_gnt_o, 1'b1);
    chk("t1_c1_lgnt", lsu_gnt_o, 1'b0);
    tick();
    if_req_i = 1'b0; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0413;
    look();
    chk("t1_c2_rv", if_rvalid_o, 1'b1);
    chk("t1_c2_rd", if_rdata_o, 32'h0000_0413);
    chk("t1_c2_lrv", lsu_rvalid_o, 1'b0);
    chk("t1_c2_lrd", lsu_rdata_o, 32'h0);
    tick();
    mem_rvalid_i = 1'b0;
    look();
    chk("t1_c3_busy", busy_o, 1'b0);

    // simultaneous IF and LSU store
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h8000_0004;
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h100;
    lsu_wdata_i = 32'hA5A5_A5A5; lsu_wstrb_i = 4'hF;
    mem_gnt_i = 1'b1;
    tick();
    look();
    chk("t2_we", mem_we_o, 1'b1);
    chk("t2_strb", mem_wstrb_o, 4'hF);
    chk("t2_addr", mem_addr_o, 32'h100);
    chk("t2_wdata", mem_wdata_o, 32'hA5A5_A5A5);
    chk("t2_lgnt", lsu_gnt_o, 1'b1);
    chk("t2_igl", if_gnt_o, 1'b0);
    tick();
    lsu_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    look();
    chk("t2_lrv", lsu_rvalid_o, 1'b1);
    chk("t2_irv", if_rvalid_o, 1'b0);
    tick();
    mem_rvalid_i = 1'b0;
    tick();
    look();
    chk("t2_if_addr", mem_addr_o, 32'h8000_0004);
    chk("t2_if_we", mem_we_o, 1'b0);
    chk("t2_if_strb", mem_wstrb_o, 4'h0);
    chk("t2_if_gnt", if_gnt_o, 1'b1);
    tick();
    if_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    look();
    chk("t2_if_rv", if_rvalid_o, 1'b1);
    tick();
    mem_rvalid_i = 1'b0;

    run_burst("t3");

    // bus stalls the grant for 5 cycles
    tick();
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h200;
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      look();
      chk($sformatf("t4_req%0d", i), mem_req_o, 1'b1);
      chk($sformatf("t4_addr%0d", i), mem_addr_o, 32'h200);
      chk($sformatf("t4_gnt%0d", i), lsu_gnt_o, 1'b0);
    end
    tick();
    mem_gnt_i = 1'b1;
    look();
    chk("t4_gnt", lsu_gnt_o, 1'b1);
    tick();
    lsu_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    look();
    chk("t4_rv", lsu_rvalid_o, 1'b1);
    tick();
    mem_rvalid_i = 1'b0;

    // reset during RESP, stale response afterwards
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h8000_0010;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h400;
    mem_gnt_i = 1'b1;
    tick();
    tick();
    if_req_i = 1'b0; lsu_req_i = 1'b0; mem_gnt_i = 1'b0;
    look();
    chk("t5_resp_busy", busy_o, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy_o, 1'b0);
    chk("t5_rst_req", mem_req_o, 1'b0);
    tick();
    tick();
    rst_n = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_0001;
    look();
    chk("t5_stale_lrv", lsu_rvalid_o, 1'b0);
    chk("t5_stale_irv", if_rvalid_o, 1'b0);
    chk("t5_busy", busy_o, 1'b0);
    tick();
    mem_rvalid_i = 1'b0;
    run_burst("t5");

    // randomized traffic
    if_seen = 1'b0;
    lsu_seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!if_req_i || if_seen) begin
        if_req_i = ($urandom_range(0, 2) == 0);
        if_addr_i = $urandom & 32'hFFFF_FFFC;
      end else if ($urandom_range(0, 31) == 0) begin
        if_req_i = 1'b0;
      end
      if (!lsu_req_i || lsu_seen) begin
        lsu_req_i = ($urandom_range(0, 1) == 0);
        lsu_we_i = $urandom_range(0, 1) == 1;
        lsu_addr_i = $urandom;
        lsu_wdata_i = $urandom;
        lsu_wstrb_i = 4'($urandom_range(0, 15));
      end else if ($urandom_range(0, 31) == 0) begin
        lsu_req_i = 1'b0;
      end
      mem_gnt_i = ($urandom_range(0, 3) != 0);
      mem_rvalid_i = ($urandom_range(0, 2) != 0);
      mem_rdata_i = $urandom;
      look();
      if_seen = if_gnt_o;
      lsu_seen = lsu_gnt_o;
    end

    tick();
    if_req_i = 1'b0; lsu_req_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
